// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap responder sitting at the execute stage.
// Turns decoder control-flow events (ECALL, EBREAK, MRET, illegal) and the
// machine external interrupt into a flush, an optional memory drain, and a
// one-cycle fetch redirect. Owns mstatus/mie/mtvec/mepc/mcause/mtval/mip and
// serves Zicsr accesses to them.
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-high reset
//   ex_valid_i            valid instruction in execute
//   ex_cflow_i            0 NORMAL, 1 ECALL, 2 EBREAK, 3 MRET
//   ex_illegal_i          decoder illegal-op flag
//   ex_pc_i, ex_instr_i   PC and raw bits of the execute instruction
//   irq_ext_i             level machine external interrupt
//   mem_busy_i            outstanding data-memory access
//   csr_we_i/addr_i/wdata_i  CSR write port; csr_rdata_o/csr_hit_o read side
//   stall_o, flush_o      pipeline control
//   redirect_valid_o/pc_o one-cycle fetch redirect
//
// State | meaning
//   IDLE     | accepting events; flush asserted combinationally on an event
//   DRAIN    | waiting for data memory to go idle
//   REDIRECT | redirect pulse; CSR side effects commit at the end of this cycle
module trap_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            ex_valid_i,
    input  logic [1:0]      ex_cflow_i,
    input  logic            ex_illegal_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [31:0]     ex_instr_i,
    input  logic            irq_ext_i,
    input  logic            mem_busy_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_hit_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);
    localparam logic [1:0] CFLOW_ECALL  = 2'd1;
    localparam logic [1:0] CFLOW_EBREAK = 2'd2;
    localparam logic [1:0] CFLOW_MRET   = 2'd3;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [XLEN-1:0] CAUSE_IRQ     = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_REDIRECT} state_t;

    state_t          state_q, state_d;
    logic            mie_q, mie_d;      // mstatus.MIE
    logic            mpie_q, mpie_d;    // mstatus.MPIE
    logic            meie_q, meie_d;    // mie.MEIE
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;

    // Event details captured at cycle 0 and held until the commit edge.
    logic            lat_mret_q, lat_mret_d;
    logic [XLEN-1:0] lat_pc_q, lat_pc_d;
    logic [XLEN-1:0] lat_cause_q, lat_cause_d;
    logic [XLEN-1:0] lat_tval_q, lat_tval_d;

    logic            ev_trap, ev_mret, ev_fire;
    logic [XLEN-1:0] ev_cause, ev_tval;

    always_comb begin
        ev_trap  = 1'b0;
        ev_mret  = 1'b0;
        ev_cause = '0;
        ev_tval  = '0;
        if (irq_ext_i && mie_q && meie_q) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_IRQ;
        end else if (ex_illegal_i) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_ILLEGAL;
            ev_tval  = XLEN'(ex_instr_i);
        end else if (ex_cflow_i == CFLOW_EBREAK) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_EBREAK;
            ev_tval  = ex_pc_i;
        end else if (ex_cflow_i == CFLOW_ECALL) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_ECALL;
        end else if (ex_cflow_i == CFLOW_MRET) begin
            ev_mret  = 1'b1;
        end
        ev_fire = ex_valid_i && (ev_trap || ev_mret) && (state_q == ST_IDLE) && !reset_i;
    end

    always_comb begin
        state_d          = state_q;
        flush_o          = 1'b0;
        stall_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        case (state_q)
            ST_IDLE: begin
                if (ev_fire) begin
                    flush_o = 1'b1;
                    state_d = mem_busy_i ? ST_DRAIN : ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                stall_o = 1'b1;
                if (!mem_busy_i) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                stall_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = lat_mret_q ? mepc_q : {mtvec_q[XLEN-1:2], 2'b00};
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lat_mret_d  = lat_mret_q;
        lat_pc_d    = lat_pc_q;
        lat_cause_d = lat_cause_q;
        lat_tval_d  = lat_tval_q;
        if (ev_fire) begin
            lat_mret_d  = ev_mret;
            lat_pc_d    = ex_pc_i;
            lat_cause_d = ev_cause;
            lat_tval_d  = ev_tval;
        end
    end

    // Software write first, then the trap/MRET commit overrides the fields it owns.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        meie_d   = meie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        if (csr_we_i) begin
            case (csr_addr_i)
                ADDR_MSTATUS: begin
                    mie_d  = csr_wdata_i[3];
                    mpie_d = csr_wdata_i[7];
                end
                ADDR_MIE:    meie_d   = csr_wdata_i[11];
                ADDR_MTVEC:  mtvec_d  = {csr_wdata_i[XLEN-1:2], 2'b00};
                ADDR_MEPC:   mepc_d   = {csr_wdata_i[XLEN-1:2], 2'b00};
                ADDR_MCAUSE: mcause_d = csr_wdata_i;
                ADDR_MTVAL:  mtval_d  = csr_wdata_i;
                default: ;
            endcase
        end
        if (state_q == ST_REDIRECT) begin
            if (lat_mret_q) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
            end else begin
                mepc_d   = lat_pc_q;
                mcause_d = lat_cause_q;
                mtval_d  = lat_tval_q;
                mpie_d   = mie_q;
                mie_d    = 1'b0;
            end
        end
    end

    always_comb begin
        csr_hit_o   = 1'b1;
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_MSTATUS: begin
                csr_rdata_o[3]     = mie_q;
                csr_rdata_o[7]     = mpie_q;
                csr_rdata_o[12:11] = 2'b11;   // MPP: machine mode only
            end
            ADDR_MIE:    csr_rdata_o[11] = meie_q;
            ADDR_MTVEC:  csr_rdata_o     = mtvec_q;
            ADDR_MEPC:   csr_rdata_o     = mepc_q;
            ADDR_MCAUSE: csr_rdata_o     = mcause_q;
            ADDR_MTVAL:  csr_rdata_o     = mtval_q;
            ADDR_MIP:    csr_rdata_o[11] = irq_ext_i;
            default:     csr_hit_o       = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            meie_q      <= 1'b0;
            mtvec_q     <= RESET_MTVEC;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            lat_mret_q  <= 1'b0;
            lat_pc_q    <= '0;
            lat_cause_q <= '0;
            lat_tval_q  <= '0;
        end else begin
            state_q     <= state_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            meie_q      <= meie_d;
            mtvec_q     <= mtvec_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            lat_mret_q  <= lat_mret_d;
            lat_pc_q    <= lat_pc_d;
            lat_cause_q <= lat_cause_d;
            lat_tval_q  <= lat_tval_d;
        end
    end
endmodule
